// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two UART command streams sharing one byte memory, round-robin per packet
module mem_port_arbiter #(
  parameter int FIFO_WIDTH = 8,
  parameter int MEM_DEPTH = 256,
  parameter logic [FIFO_WIDTH-1:0] CMD_WRITE = 8'd49,
  parameter logic [FIFO_WIDTH-1:0] CMD_READ = 8'd48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rx_fifo_empty,
  output logic [1:0]            rx_fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] din0,
  input  logic [FIFO_WIDTH-1:0] din1,
  input  logic [1:0]            tx_fifo_full,
  output logic [1:0]            tx_fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic [1:0]            grant,
  output logic [5:0]            state_leds
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [3:0] {
    IDLE, RD_CMD, CAP_CMD, RD_ADDR, CAP_ADDR, RD_DATA, CAP_DATA, MEM_WR, MEM_RD, MEM_WAIT, ECHO
  } state_t;
  state_t state, state_n;
  logic [1:0] grant_n;
  logic last_served, last_n, is_wr, g;
  logic [FIFO_WIDTH-1:0] din_g, data, mem_q;
  logic [AW-1:0] addr;
  logic [FIFO_WIDTH-1:0] mem [MEM_DEPTH];
  assign g = grant[1];
  assign din_g = g ? din1 : din0;
  assign rx_fifo_rd_en = (state == RD_CMD || state == RD_ADDR || state == RD_DATA) ? grant & ~rx_fifo_empty : 2'b00;
  assign tx_fifo_wr_en = (state == ECHO) ? grant & ~tx_fifo_full : 2'b00;
  assign state_leds = (state == IDLE) ? 6'b000001 :
                      (state == RD_CMD || state == CAP_CMD) ? 6'b000010 :
                      (state == RD_ADDR || state == CAP_ADDR) ? 6'b000100 :
                      (state == RD_DATA || state == CAP_DATA) ? 6'b001000 :
                      (state == ECHO) ? 6'b100000 : 6'b010000;
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n = last_served;
    case (state)
      IDLE: if (rx_fifo_empty != 2'b11) begin
        // on a tie the port that was not served last wins
        grant_n = (rx_fifo_empty == 2'b00) ? (last_served ? 2'b01 : 2'b10) : (rx_fifo_empty[0] ? 2'b10 : 2'b01);
        state_n = RD_CMD;
      end
      RD_CMD:   state_n = rx_fifo_empty[g] ? RD_CMD : CAP_CMD;
      CAP_CMD:  if (din_g == CMD_WRITE || din_g == CMD_READ) state_n = RD_ADDR;
                else begin
                  state_n = IDLE;
                  grant_n = 2'b00;
                  last_n = g;
                end
      RD_ADDR:  state_n = rx_fifo_empty[g] ? RD_ADDR : CAP_ADDR;
      CAP_ADDR: state_n = is_wr ? RD_DATA : MEM_RD;
      RD_DATA:  state_n = rx_fifo_empty[g] ? RD_DATA : CAP_DATA;
      CAP_DATA: state_n = MEM_WR;
      MEM_WR: begin
        state_n = IDLE;
        grant_n = 2'b00;
        last_n = g;
      end
      MEM_RD:   state_n = MEM_WAIT;
      MEM_WAIT: state_n = ECHO;
      ECHO: if (!tx_fifo_full[g]) begin
        state_n = IDLE;
        grant_n = 2'b00;
        last_n = g;
      end
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      last_served <= 1'b1;
      dout <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_served <= last_n;
      if (state == MEM_WAIT) dout <= mem_q;
    end
  end
  always_ff @(posedge clk) begin
    if (state == CAP_CMD) is_wr <= (din_g == CMD_WRITE);
    if (state == CAP_ADDR) addr <= din_g[AW-1:0];
    if (state == CAP_DATA) data <= din_g;
    if (state == MEM_WR && !rst) mem[addr] <= data;
    mem_q <= mem[addr];
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with FIFO models for both ports
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic [1:0] rx_fifo_empty = 2'b11, rx_fifo_rd_en, tx_fifo_full = 2'b00, tx_fifo_wr_en, grant;
  logic [7:0] din0 = 0, din1 = 0, dout;
  logic [5:0] state_leds;
  logic [7:0] rxq0[$], rxq1[$], exp_tx0[$], exp_tx1[$];
  logic [1:0] exp_grant[$];
  logic [1:0] rd_s = 0, prev_g = 0;
  logic chk_lat = 0;
  int checks = 0, errors = 0, cyc = 0, rise_cyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .rx_fifo_empty(rx_fifo_empty), .rx_fifo_rd_en(rx_fifo_rd_en),
    .din0(din0), .din1(din1), .tx_fifo_full(tx_fifo_full), .tx_fifo_wr_en(tx_fifo_wr_en),
    .dout(dout), .grant(grant), .state_leds(state_leds)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RX FIFO model: pop a cycle after a sampled rd_en, then refresh empty flags
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_s[0] && rxq0.size() > 0) din0 = rxq0.pop_front();
    if (rd_s[1] && rxq1.size() > 0) din1 = rxq1.pop_front();
    #1;
    rx_fifo_empty = {rxq1.size() == 0, rxq0.size() == 0};
  end

  // Monitor: grant order, packet timing, TX data and handshake invariants
  always @(negedge clk) begin
    cyc++;
    rd_s = rx_fifo_rd_en;
    if (!rst) begin
      chk("wr_while_full", int'(tx_fifo_wr_en & tx_fifo_full), 0);
      chk("rd_outside_grant", int'(rx_fifo_rd_en & ~grant), 0);
      if (grant != 0 && prev_g == 0) begin
        rise_cyc = cyc;
        if (exp_grant.size() == 0) chk("unexpected_grant", int'(grant), 0);
        else chk("grant_order", int'(grant), int'(exp_grant.pop_front()));
      end
      if (grant != 0 && prev_g != 0) chk("grant_hold", int'(grant), int'(prev_g));
      if (grant == 0 && prev_g != 0 && chk_lat) chk("packet_len", cyc - rise_cyc, 7);
      if (tx_fifo_wr_en[0]) begin
        if (exp_tx0.size() == 0) chk("tx0_unexpected_write", int'(dout), -1);
        else chk("tx0_data", int'(dout), int'(exp_tx0.pop_front()));
        if (chk_lat) chk("read_latency", cyc - rise_cyc, 6);
      end
      if (tx_fifo_wr_en[1]) begin
        if (exp_tx1.size() == 0) chk("tx1_unexpected_write", int'(dout), -1);
        else chk("tx1_data", int'(dout), int'(exp_tx1.pop_front()));
        if (chk_lat) chk("read_latency", cyc - rise_cyc, 6);
      end
    end
    prev_g = grant;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [7:0] b);
    if (p == 0) rxq0.push_back(b);
    else rxq1.push_back(b);
  endtask

  task automatic wr(input int p, input logic [7:0] a, input logic [7:0] d);
    exp_grant.push_back(p == 0 ? 2'b01 : 2'b10);
    push(p, 8'd49); push(p, a); push(p, d);
  endtask

  task automatic rd(input int p, input logic [7:0] a, input logic [7:0] e);
    exp_grant.push_back(p == 0 ? 2'b01 : 2'b10);
    if (p == 0) exp_tx0.push_back(e);
    else exp_tx1.push_back(e);
    push(p, 8'd48); push(p, a);
  endtask

  task automatic settle;
    int n = 0;
    while ((exp_grant.size() != 0 || rxq0.size() != 0 || rxq1.size() != 0 ||
            exp_tx0.size() != 0 || exp_tx1.size() != 0 || grant != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("settle_timeout", int'(n >= 3000), 0);
    tick(2);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_leds"}, int'(state_leds), 1);
    chk({tag, "_dout"}, int'(dout), 0);
    chk({tag, "_rd_en"}, int'(rx_fifo_rd_en), 0);
    chk({tag, "_wr_en"}, int'(tx_fifo_wr_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    tick(2);
    chk_reset("reset");
    rst = 0;
    tick(1);
    // single-port write then read with exact timing
    chk_lat = 1;
    wr(0, 10, 65);
    rd(0, 10, 65);
    settle;
    // both ports preloaded, fresh reset so port 0 wins the first tie
    rst = 1; tick(1); rst = 0; tick(1);
    wr(0, 20, 66);
    wr(1, 21, 67);
    rd(0, 21, 67);
    rd(1, 20, 66);
    settle;
    chk_lat = 0;
    // port 0 starves mid-packet; port 1 must wait for the whole write
    exp_grant.push_back(2'b01);
    push(0, 8'd49);
    tick(1);
    rd(1, 30, 68);
    tick(4);
    push(0, 8'd30);
    tick(5);
    push(0, 8'd68);
    settle;
    // TX backpressure on port 1
    for (int i = 0; i < 10; i++) wr(0, 8'(10 + i), 8'(65 + i));
    settle;
    tx_fifo_full[1] = 1'b1;
    for (int i = 0; i < 10; i++) rd(1, 8'(10 + i), 8'(65 + i));
    n = 0;
    while (state_leds != 6'b100000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("echo_reached", int'(n < 100), 1);
    repeat (20) @(negedge clk);
    chk("stall_leds", int'(state_leds), 32);
    chk("stall_wr_en", int'(tx_fifo_wr_en), 0);
    chk("stall_grant", int'(grant), 2);
    tick(1);
    tx_fifo_full[1] = 1'b0;
    settle;
    // bad opcode dropped after one byte, following write lands
    exp_grant.push_back(2'b01);
    push(0, 8'h55);
    wr(0, 40, 69);
    rd(0, 40, 69);
    settle;
    // reset during MEM_WAIT of a port 1 read; last served was port 0
    exp_grant.push_back(2'b10);
    push(1, 8'd48); push(1, 8'd10);
    n = 0;
    while (state_leds != 6'b010000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mem_rd_reached", int'(n < 100), 1);
    tick(1);
    rst = 1;
    tick(1);
    rst = 0;
    chk_reset("mid_reset");
    wr(0, 50, 1);
    wr(1, 51, 2);
    settle;
    chk("leftover", exp_grant.size() + exp_tx0.size() + exp_tx1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one 256x8 byte memory between two independent UART command streams, port 0 and port 1. Each port has its own RX FIFO (command bytes in) and TX FIFO (read data out). The block accepts the same packet protocol as the single-port memory controller. It arbitrates round-robin at packet granularity, so the bytes of one packet are never interleaved with another port's packet, and it returns each read result only to the port that issued it.

Parameters:
FIFO_WIDTH, 8, byte width of all FIFO data paths
MEM_DEPTH, 256, memory entries; address width is log2(MEM_DEPTH)=8
CMD_WRITE, 8'd49, opcode for a write packet: cmd, addr, data
CMD_READ, 8'd48, opcode for a read packet: cmd, addr

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_fifo_empty  in  2  per-port RX FIFO empty; bit p is port p
rx_fifo_rd_en  out  2  per-port RX FIFO read enable; at most one bit high
din0  in  8  port 0 RX FIFO dout; valid the cycle after rd_en
din1  in  8  port 1 RX FIFO dout; valid the cycle after rd_en
tx_fifo_full  in  2  per-port TX FIFO full
tx_fifo_wr_en  out  2  per-port TX FIFO write enable; at most one bit high
dout  out  8  read data to the TX FIFOs; shared bus, qualified by tx_fifo_wr_en
grant  out  2  one-hot owner of the current packet; 0 in IDLE
state_leds  out  6  one-hot encoding of the current state, for debug

Behaviour:
- States: IDLE, RD_CMD, CAP_CMD, RD_ADDR, CAP_ADDR, RD_DATA, CAP_DATA, MEM_WR, MEM_RD, MEM_WAIT, ECHO. state_leds maps to the state group: IDLE, CMD, ADDR, DATA, MEM, ECHO.
- Reset: state=IDLE; grant=0; all rd_en/wr_en=0; dout=0; last_served=1, so port 0 wins the first tie. Memory contents are NOT reset. Reset mid-packet abandons the packet, and any bytes already consumed are lost.
- IDLE: if exactly one rx_fifo_empty bit is 0, grant that port. If both are 0, grant the port != last_served. Register grant and go to RD_CMD. If neither is ready, stay in IDLE.
- RD_x states: assert rx_fifo_rd_en[g] for one cycle only when rx_fifo_empty[g]=0, then go to CAP_x. If the FIFO is empty, hold in RD_x with rd_en=0 and keep grant. The other port is never served mid-packet.
- CAP_CMD: latch din of the granted port. CMD_WRITE or CMD_READ goes to RD_ADDR. Any other byte is dropped: go to IDLE and set last_served=g.
- CAP_ADDR: latch addr. A write goes to RD_DATA; a read goes to MEM_RD.
- CAP_DATA: latch data and go to MEM_WR.
- MEM_WR: write mem[addr]=data at the end of the cycle, set last_served=g, go to IDLE.
- MEM_RD: present addr to the synchronous-read memory. MEM_WAIT: memory output is valid; register it into dout. Then go to ECHO.
- ECHO: if tx_fifo_full[g]=0, assert tx_fifo_wr_en[g] for exactly one cycle, set last_served=g, go to IDLE. If tx_fifo_full[g]=1, hold in ECHO with dout stable and wr_en=0, indefinitely.
- No-stall timing, with the grant decided in IDLE at cycle T:
  - Write: memory updated at the clock edge ending T+7; back in IDLE at T+8.
  - Read: tx_fifo_wr_en high during T+7; back in IDLE at T+8.
- Fairness: with both ports continuously non-empty, grants strictly alternate 0,1,0,1. Dropped bad opcodes count as served.
- Same-address access from both ports: ordered by grant order. A read never returns a partially written value.
- Outputs rx_fifo_rd_en, tx_fifo_wr_en and grant are registered or decoded from registered state only. They have no combinational path from inputs except the empty/full qualification of the current enable.

Test Plan:
- Port 0 only: write (49,10,'A'=65), then read (48,10) -> mem[10]=65 by T+7; port 0 TX receives 65; port 1 TX receives nothing; grant=01 throughout.
- Both ports preloaded: P0 write (49,20,66), P1 write (49,21,67), P0 read 21, P1 read 20 -> grants alternate 01,10,01,10; P0 TX gets 67; P1 TX gets 66.
- Mid-packet starvation: P0 pushes cmd 49, then 5 idle cycles, then addr 30, then 5 idle cycles, then data 68; P1 pushes a full read of addr 30 meanwhile -> grant stays 01 until P0's write completes; mem[30]=68; P1 then reads 68.
- TX backpressure: hold P1 TX FIFO (depth 8) full, P1 sends 10 reads of addrs 10..19 preloaded 65..74 -> FSM stalls in ECHO with wr_en=0; draining yields 65..74 in order with none lost or duplicated.
- Bad opcode: P0 sends 0x55, then write (49,40,69) -> 0x55 dropped after one byte; mem[40]=69; no TX write.
- Reset during MEM_WAIT of a P1 read -> outputs return to reset values next cycle; no TX write; the next tie grants port 0.
